fp_wb_queue: RTL and testbench

FP_WB_QUEUE -- requirements
Module: fp_wb_queue

---
 rtl/fp_wb_pkg.sv | 16 +
 rtl/fp_wb_fifo.sv | 64 ++++++
 rtl/fp_wb_queue.sv | 102 ++++++++++
 tb/tb_fp_wb_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types and widths for the FP writeback queue.
// Optional same-cycle bypass is enabled with FP_WB_BYPASS_EN.
package fp_wb_pkg;

    localparam int TAG_W     = 5;
    localparam int DST_W     = 5;
    localparam int DATA_W    = 32;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// In-order result storage for the FP writeback queue.
// Head is shown combinationally and reads zero when empty.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  fp_wb_entry_t wdata_i,
    output fp_wb_entry_t rdata_o,
    output logic [AW:0]  count_o,
    output logic         empty_o,
    output logic         full_o
);

    fp_wb_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs when full
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next state; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
        if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only visible while counted
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fp_wb_queue.sv
// FP writeback queue: buffers FPU results for the CDB with issue credits.
// Define FP_WB_BYPASS_EN for 0-cycle forwarding into an empty queue.
module fp_wb_queue
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_fire,
    input  logic              wr_en_fp,
    input  logic [TAG_W-1:0]  tag_fp,
    input  logic [DST_W-1:0]  dst_fp,
    input  logic [DATA_W-1:0] result,
    input  logic              cdb_grant,
    output logic              cdb_req,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DST_W-1:0]  cdb_dst,
    output logic [DATA_W-1:0] cdb_data,
    output logic              can_issue,
    output logic              overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    fp_wb_entry_t  in_ent, head_ent, out_ent;
    logic [CW-1:0] occ;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW:0]   credit_sum;
    logic          overflow_q, overflow_d;
    logic          empty, full;
    logic          push, pop, issue_ok, byp;

    assign in_ent = '{tag: tag_fp, dst: dst_fp, data: result};

    fp_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_ent),
        .rdata_o (head_ent),
        .count_o (occ),
        .empty_o (empty),
        .full_o  (full)
    );

`ifdef FP_WB_BYPASS_EN
    // Empty queue forwards the arriving result straight to the CDB
    assign byp     = empty & wr_en_fp & ~rst;
    assign out_ent = byp ? in_ent : head_ent;
    assign cdb_req = ~empty | byp;
`else
    // Every result is registered before it can be broadcast
    assign byp     = 1'b0;
    assign out_ent = head_ent;
    assign cdb_req = ~empty;
`endif

    assign cdb_valid = cdb_req & cdb_grant;
    assign cdb_tag   = out_ent.tag;
    assign cdb_dst   = out_ent.dst;
    assign cdb_data  = out_ent.data;

    // A granted bypass consumes the result without storing it
    assign pop  = cdb_valid & ~empty;
    assign push = wr_en_fp & ~(byp & cdb_grant);

    assign credit_sum = {1'b0, occ} + {1'b0, inflight_q};
    assign can_issue  = credit_sum < (CW+1)'(DEPTH);
    assign issue_ok   = issue_fire & can_issue;
    assign overflow   = overflow_q;

    // Credit and protocol-error next state
    always_comb begin
        inflight_d = inflight_q;
        if (issue_ok && !wr_en_fp) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue_ok && wr_en_fp && inflight_q != '0) begin
            inflight_d = inflight_q - CW'(1);
        end
        overflow_d = overflow_q
                   | (issue_fire & ~can_issue)
                   | (wr_en_fp & full & ~pop)
                   | (wr_en_fp & (inflight_q == '0));
    end

    // Credit counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fp_wb_queue.sv
// Directed scoreboard bench for fp_wb_queue (DEPTH = 4).
// Latency expectations follow FP_WB_BYPASS_EN when it is defined.
module tb_fp_wb_queue;

    import fp_wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef FP_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              issue_fire;
    logic              wr_en_fp;
    logic [TAG_W-1:0]  tag_fp;
    logic [DST_W-1:0]  dst_fp;
    logic [DATA_W-1:0] result;
    logic              cdb_grant;
    logic              cdb_req;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DST_W-1:0]  cdb_dst;
    logic [DATA_W-1:0] cdb_data;
    logic              can_issue;
    logic              overflow;

    fp_wb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    fp_wb_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_fire (issue_fire),
        .wr_en_fp   (wr_en_fp),
        .tag_fp     (tag_fp),
        .dst_fp     (dst_fp),
        .result     (result),
        .cdb_grant  (cdb_grant),
        .cdb_req    (cdb_req),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_dst    (cdb_dst),
        .cdb_data   (cdb_data),
        .can_issue  (can_issue),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Compare any broadcast against the scoreboard, then advance a cycle
    task automatic tick();
        fp_wb_entry_t e;
        @(negedge clk);
        if (cdb_valid === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("cdb_tag", 32'(cdb_tag), 32'(e.tag));
                check("cdb_dst", 32'(cdb_dst), 32'(e.dst));
                check("cdb_data", cdb_data, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [4:0] t, input logic [4:0] d,
                            input logic [31:0] r, input bit expect_keep);
        wr_en_fp = 1'b1;
        tag_fp   = t;
        dst_fp   = d;
        result   = r;
        if (expect_keep) sb.push_back('{tag: t, dst: d, data: r});
    endtask

    task automatic idle_wr();
        wr_en_fp = 1'b0;
        tag_fp   = '0;
        dst_fp   = '0;
        result   = '0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req"}, 32'(cdb_req), 32'd0);
        check({name, "_valid"}, 32'(cdb_valid), 32'd0);
        check({name, "_tag"}, 32'(cdb_tag), 32'd0);
        check({name, "_dst"}, 32'(cdb_dst), 32'd0);
        check({name, "_data"}, cdb_data, 32'd0);
        check({name, "_ovf"}, 32'(overflow), 32'd0);
        check({name, "_can"}, 32'(can_issue), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue_fire = 1'b1;
            tick();
        end
        issue_fire = 1'b0;
    endtask

    task automatic fill4(input logic [4:0] base);
        issue_n(4);
        for (int i = 0; i < 4; i++) begin
            drive_wr(base + 5'(i), 5'(i + 1), 32'h3f80_0000 + 32'(i), 1'b1);
            tick();
        end
        idle_wr();
    endtask

    initial begin
        rst        = 1'b1;
        issue_fire = 1'b0;
        cdb_grant  = 1'b0;
        idle_wr();
        #2;
        do_reset();

        // Single op through the queue
        cdb_grant = 1'b1;
        issue_n(1);
        check("t1_inflight", 32'(dut.inflight_q), 32'd1);
        tick();
        tick();
        tick();
        drive_wr(5'd3, 5'd7, 32'h4040_0000, 1'b1);
        #1;
        check("t1_valid_c0", 32'(cdb_valid), 32'(BYP));
        tick();
        idle_wr();
        #1;
        check("t1_valid_c1", 32'(cdb_valid), 32'(!BYP));
        tick();
        check("t1_req_idle", 32'(cdb_req), 32'd0);
        check("t1_can", 32'(can_issue), 32'd1);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_inflight0", 32'(dut.inflight_q), 32'd0);

        // Credit limit
        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_fire = 1'b1;
            tick();
            check("t2_can", 32'(can_issue), 32'(i < 3));
        end
        check("t2_ovf_pre", 32'(overflow), 32'd0);
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_inflight", 32'(dut.inflight_q), 32'd4);
        tick();
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        do_reset();

        // Fill then drain in order
        fill4(5'd10);
        check("t3_count", 32'(dut.u_fifo.count_q), 32'd4);
        check("t3_req", 32'(cdb_req), 32'd1);
        check("t3_head", 32'(cdb_tag), 32'd10);
        check("t3_can", 32'(can_issue), 32'd0);
        check("t3_ovf", 32'(overflow), 32'd0);
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_valid", 32'(cdb_valid), 32'd1);
            tick();
        end
        check("t3_req_end", 32'(cdb_req), 32'd0);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        check("t3_can_end", 32'(can_issue), 32'd1);
        cdb_grant = 1'b0;

        // Full: drop without pop, keep with same-cycle pop.
        // A result into a full queue never has a credit behind it,
        // so the error flag is expected to rise here.
        fill4(5'd10);
        drive_wr(5'd21, 5'd21, 32'hdead_0021, 1'b0);
        tick();
        idle_wr();
        check("t4_drop_cnt", 32'(dut.u_fifo.count_q), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd1);
        cdb_grant = 1'b1;
        drive_wr(5'd20, 5'd20, 32'hbeef_0020, 1'b1);
        tick();
        idle_wr();
        cdb_grant = 1'b0;
        check("t4_pp_cnt", 32'(dut.u_fifo.count_q), 32'd4);
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t4_req_end", 32'(cdb_req), 32'd0);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        cdb_grant = 1'b0;
        do_reset();

        // Reset mid-drain
        issue_n(3);
        for (int i = 0; i < 3; i++) begin
            drive_wr(5'd30 + 5'(i), 5'(i), 32'h4100_0000 + 32'(i), 1'b1);
            tick();
        end
        idle_wr();
        cdb_grant = 1'b1;
        tick();
        check("t5_count2", 32'(dut.u_fifo.count_q), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        check("t5_count0", 32'(dut.u_fifo.count_q), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_no_stale", 32'(cdb_valid), 32'd0);
            tick();
        end

        // Empty-queue latency
        issue_n(1);
        drive_wr(5'd9, 5'd4, 32'h3f00_0000, 1'b1);
        #1;
        check("t6_valid_c0", 32'(cdb_valid), 32'(BYP));
        tick();
        idle_wr();
        check("t6_count", 32'(dut.u_fifo.count_q), 32'(!BYP));
        #1;
        check("t6_valid_c1", 32'(cdb_valid), 32'(!BYP));
        tick();
        check("t6_count_end", 32'(dut.u_fifo.count_q), 32'd0);
        check("t6_req_end", 32'(cdb_req), 32'd0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
